piso_stream: RTL and testbench
==============================

# piso_stream

Parametrised parallel-in/serial-out serializer with a valid/ready input handshake, a one-word holding buffer for gapless back-to-back frames, and per-word selectable bit order. It sits between a word-oriented producer and a bit-serial link. The downstream side paces the output with `shift_en`, and framing strobes mark the first and last bit of every word.

## Interface
- `WIDTH`, default 8: word width in bits; legal range is `WIDTH >= 2`.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: producer presents a word.
- `in_ready` output, 1 bit: block can accept a word this cycle.
- `parallel_in` input, `WIDTH` bits: word to serialize.
- `msb_first` input, 1 bit: captured with the word; 1 = MSB first, 0 = LSB first.
- `shift_en` input, 1 bit: downstream consumes the current bit at this edge.
- `serial_out` output, 1 bit: current serial bit; 0 whenever `serial_valid` = 0.
- `serial_valid` output, 1 bit: `serial_out` carries a data bit.
- `frame_start` output, 1 bit: current bit is bit 0 of the frame.
- `frame_end` output, 1 bit: current bit is the last bit of the frame.
- `busy` output, 1 bit: a word is shifting or held.

## Operation
- **Internal state:**
  - `SR`: `WIDTH`-bit shift register, with mode flag `sr_msb`.
  - `CNT`: bits remaining, `$clog2(WIDTH+1)` bits wide.
  - `HB`: holding buffer, with flag `hb_msb` and `hb_full`.
  - `STATE`: one of `IDLE`, `SHIFT`.
- **Accept:** a word is accepted when `in_valid & in_ready` at a rising edge. `in_ready = ~hb_full` and is registered-only, with no combinational path from `in_valid`.
- **IDLE, word accepted:** load `SR` from `parallel_in`, `sr_msb` from `msb_first`, `CNT = WIDTH`; go to `SHIFT`.
- **SHIFT, `shift_en` = 0:** `SR` and `CNT` hold.
- **SHIFT, `shift_en` = 1, `CNT > 1`:**
  - MSB mode shifts left and LSB mode shifts right, filling with 0.
  - `CNT` decrements.
- **SHIFT, `shift_en` = 1, `CNT == 1` (last bit consumed):**
  - If `hb_full`: load `SR` from `HB`, `CNT = WIDTH`, clear `hb_full`, stay in `SHIFT`.
  - Else, if a word is accepted at the same edge: load it directly into `SR`, `CNT = WIDTH`, stay in `SHIFT`.
  - Else: `CNT = 0`, go to `IDLE`.
- **SHIFT, word accepted, not covered by the direct load above:** write `HB` and `hb_msb`, set `hb_full`. A word cannot arrive while `hb_full` is set because `in_ready = 0`.
- **Output decode:**
  - `serial_out`: `SR[WIDTH-1]` if `sr_msb`, else `SR[0]`; forced to 0 when `STATE == IDLE`.
  - `serial_valid = (STATE == SHIFT)`.
  - `frame_start = serial_valid & (CNT == WIDTH)`.
  - `frame_end = serial_valid & (CNT == 1)`.
  - `busy = (STATE == SHIFT) | hb_full`.
- **Mode capture:** `msb_first` is sampled only at acceptance. Changing it mid-frame has no effect on the frame in flight.

## Timing
- **Reset values:**
  - Outputs: `serial_out` = 0, `serial_valid` = 0, `frame_start` = 0, `frame_end` = 0, `busy` = 0, `in_ready` = 1.
  - Internal: `SR` = 0, `CNT` = 0, `hb_full` = 0, `STATE = IDLE`.
- **Reset mid-operation:** `rst` asserted mid-frame immediately discards both `SR` and `HB`. Outputs return to their reset values without waiting for a clock edge.
- **Latency:** a word accepted at edge N from `IDLE` drives its first bit, with `frame_start = 1`, in the cycle after edge N.
- **Bit pacing:** each bit is held until an edge with `shift_en = 1`. A frame occupies at least `WIDTH` cycles.
- **Throughput:** with `shift_en` held high and words always offered, the output is gapless at 1 bit per cycle. `frame_end` of word k is followed directly by `frame_start` of word k+1.
- **`in_ready` behaviour:**
  - Deasserts the cycle after `HB` fills.
  - Reasserts the cycle after the `HB`→`SR` transfer.
- **Pre-loaded words:** at most two words are buffered: one in `SR`, one in `HB`.

## Test plan
- **Reset:** assert `rst` asynchronously between edges → all outputs take their reset values immediately; `in_ready` = 1.
- **Single MSB-first word:** `WIDTH` = 8, accept 0xCC with `msb_first` = 1, `shift_en` = 1 → `serial_out` = 1,1,0,0,1,1,0,0 on 8 consecutive cycles. `frame_start` on bit 1, `frame_end` on bit 8, then `serial_valid` = 0.
- **Single LSB-first word:** accept 0xD0 with `msb_first` = 0 → `serial_out` = 0,0,0,0,1,0,1,1. Toggling `msb_first` mid-frame changes nothing.
- **Back-to-back words:** offer 0xCC then 0xD0 continuously, `shift_en` = 1 → 16 contiguous valid bits with no gap. `in_ready` = 0 from the edge after the second accept until the `HB`→`SR` transfer; a third word waits.
- **Stall:** `shift_en` = 0 for 3 cycles after bit 3 of 0xA5 → `serial_out`, `CNT` and strobes hold. The sequence then resumes at bit 4, and the frame spans 11 cycles.
- **Reset mid-operation:** `rst` pulse during bit 5 with `HB` full → `serial_valid` = 0 and `busy` = 0 immediately. After release, the next accepted word starts with `frame_start`, and no stale bits appear.

Source files
------------

// File: rtl/piso_stream_if.sv
// rtl/piso_stream_if.sv - handshake and serial-link signal bundle for piso_stream
interface piso_stream_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] parallel_in;
    logic             msb_first;
    logic             shift_en;
    logic             serial_out;
    logic             serial_valid;
    logic             frame_start;
    logic             frame_end;
    logic             busy;

    // Producer plus downstream pacing side
    modport master (
        output in_valid, parallel_in, msb_first, shift_en,
        input  in_ready, serial_out, serial_valid, frame_start, frame_end, busy
    );

    // Serializer side
    modport slave (
        input  in_valid, parallel_in, msb_first, shift_en,
        output in_ready, serial_out, serial_valid, frame_start, frame_end, busy
    );
endinterface

// File: rtl/piso_stream.sv
// rtl/piso_stream.sv - parallel-in/serial-out serializer with one-word holding buffer
module piso_stream #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    piso_stream_if.slave s
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sr;
    logic             r_sr_msb;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hb;
    logic             r_hb_msb;
    logic             r_hb_full;

    logic w_accept;
    logic w_last;
    logic w_direct;

    // in_ready depends only on the registered buffer flag, never on in_valid
    assign w_accept = s.in_valid & ~r_hb_full;
    assign w_last   = (r_state == SHIFT) & s.shift_en & (r_cnt == CNT_ONE);
    // Last bit leaves with an empty buffer: a newly accepted word bypasses HB
    assign w_direct = w_last & ~r_hb_full & w_accept;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode: leave SHIFT only when the last bit goes with nothing queued
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SHIFT;
            SHIFT:   if (w_last && !r_hb_full && !w_accept) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shift register, bit counter and mode flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr     <= '0;
            r_sr_msb <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == IDLE) begin
            if (w_accept) begin
                r_sr     <= s.parallel_in;
                r_sr_msb <= s.msb_first;
                r_cnt    <= CNT_FULL;
            end
        end else if (s.shift_en) begin
            if (r_cnt != CNT_ONE) begin
                r_sr  <= r_sr_msb ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
                r_cnt <= r_cnt - CNT_ONE;
            end else if (r_hb_full) begin
                r_sr     <= r_hb;
                r_sr_msb <= r_hb_msb;
                r_cnt    <= CNT_FULL;
            end else if (w_accept) begin
                r_sr     <= s.parallel_in;
                r_sr_msb <= s.msb_first;
                r_cnt    <= CNT_FULL;
            end else begin
                r_sr  <= '0;
                r_cnt <= '0;
            end
        end
    end

    // Holding buffer: filled by an accept during SHIFT, drained at the last bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hb      <= '0;
            r_hb_msb  <= 1'b0;
            r_hb_full <= 1'b0;
        end else if (r_state == SHIFT) begin
            if (w_last && r_hb_full) begin
                r_hb_full <= 1'b0;
            end else if (w_accept && !w_direct) begin
                r_hb      <= s.parallel_in;
                r_hb_msb  <= s.msb_first;
                r_hb_full <= 1'b1;
            end
        end
    end

    // Output decode from registered state only
    always_comb begin
        s.in_ready     = ~r_hb_full;
        s.serial_valid = (r_state == SHIFT);
        s.serial_out   = 1'b0;
        if (r_state == SHIFT) s.serial_out = r_sr_msb ? r_sr[WIDTH-1] : r_sr[0];
        s.frame_start  = (r_state == SHIFT) & (r_cnt == CNT_FULL);
        s.frame_end    = (r_state == SHIFT) & (r_cnt == CNT_ONE);
        s.busy         = (r_state == SHIFT) | r_hb_full;
    end
endmodule

// File: tb/tb_piso_stream.sv
// tb/tb_piso_stream.sv - scoreboard bench for piso_stream
module tb_piso_stream;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    piso_stream_if #(.WIDTH(W)) bus ();
    piso_stream #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .s(bus.slave));

    typedef struct {
        logic b;
        logic fs;
        logic fe;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] log_bits;
    int          n_valid;
    int          run;
    int          max_run;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bit order of one word, derived from the word and its mode
    task automatic push_word(input logic [W-1:0] w, input logic m);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            e.b  = m ? w[W-1-i] : w[i];
            e.fs = (i == 0);
            e.fe = (i == W-1);
            q.push_back(e);
        end
    endtask

    // Monitor: compare presented bit with scoreboard head; pop on consumption
    always @(negedge clk) begin
        if (!rst) begin
            check("serial_valid", 32'(bus.serial_valid), 32'(q.size() != 0));
            check("busy", 32'(bus.busy), 32'(q.size() != 0));
            check("in_ready", 32'(bus.in_ready), 32'(q.size() <= W));
            if (q.size() != 0) begin
                check("serial_out", 32'(bus.serial_out), 32'(q[0].b));
                check("frame_start", 32'(bus.frame_start), 32'(q[0].fs));
                check("frame_end", 32'(bus.frame_end), 32'(q[0].fe));
                n_valid++;
                run++;
                if (run > max_run) max_run = run;
                if (bus.shift_en) begin
                    log_bits = {log_bits[62:0], bus.serial_out};
                    void'(q.pop_front());
                end
            end else begin
                check("idle_out", {29'd0, bus.serial_out, bus.frame_start, bus.frame_end}, 32'd0);
                run = 0;
            end
            if (bus.in_valid && bus.in_ready) push_word(bus.parallel_in, bus.msb_first);
        end
    end

    task automatic send(input logic [W-1:0] w, input logic m);
        int k;
        bus.in_valid    = 1'b1;
        bus.parallel_in = w;
        bus.msb_first   = m;
        k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck 0 expected 1");
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic clear_stats();
        log_bits = '0;
        n_valid  = 0;
        max_run  = 0;
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {26'd0, bus.serial_out, bus.serial_valid, bus.frame_start,
                     bus.frame_end, bus.busy, bus.in_ready}, 32'h1);
    endtask

    initial begin
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.parallel_in = '0;
        bus.msb_first   = 1'b0;
        bus.shift_en    = 1'b0;
        run             = 0;
        clear_stats();
        #2 check_reset_outputs("reset_values");
        @(posedge clk);
        #1 rst = 1'b0;

        // Single MSB-first word
        bus.shift_en = 1'b1;
        clear_stats();
        send(8'hCC, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("msb_word_bits", 32'(log_bits[7:0]), 32'hCC);
        check("msb_word_len", 32'(n_valid), 32'd8);

        // Single LSB-first word with msb_first toggling mid-frame
        clear_stats();
        send(8'hD0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 bus.msb_first = ~bus.msb_first;
        end
        check("lsb_word_bits", 32'(log_bits[7:0]), 32'h0B);

        // Back-to-back words, third one waits on in_ready
        clear_stats();
        send(8'hCC, 1'b1);
        send(8'hD0, 1'b0);
        send(8'hA5, 1'b1);
        repeat (30) @(posedge clk);
        #1;
        check("b2b_bits", 32'(log_bits[23:0]), 32'hCC0BA5);
        check("b2b_gapless", 32'(max_run), 32'd24);

        // Stall after bit 3
        clear_stats();
        send(8'hA5, 1'b1);
        repeat (3) @(posedge clk);
        #1 bus.shift_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.shift_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("stall_bits", 32'(log_bits[7:0]), 32'hA5);
        check("stall_span", 32'(n_valid), 32'd11);

        // Reset during bit 5 with the holding buffer full
        send(8'hCC, 1'b1);
        send(8'hD0, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset_outputs("midop_reset");
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_quiet", 32'(n_valid), 32'd0);
        send(8'h96, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        check("post_reset_bits", 32'(log_bits[7:0]), 32'h69);
        check("post_reset_len", 32'(n_valid), 32'd8);

        // Randomized traffic and pacing
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid    = ($urandom_range(0, 2) != 0);
            bus.parallel_in = W'($urandom);
            bus.msb_first   = $urandom_range(0, 1) == 1;
            bus.shift_en    = ($urandom_range(0, 3) != 0);
        end
        #1 bus.in_valid = 1'b0;
        bus.shift_en = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("drain_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
